// File: rtl/gpiotest_pkg.sv
// Shared types and defaults for the GPIO pattern sequencer.
package gpiotest_pkg;

  typedef enum logic [1:0] {
    WALK1    = 2'd0,
    WALK0    = 2'd1,
    COUNT    = 2'd2,
    LOOPBACK = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    LB_DRIVE  = 3'd2,
    LB_SAMPLE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int NUM_PINS_DEFAULT = 32;
  localparam int CLK_HZ_DEFAULT   = 12_000_000;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for the asynchronous pad inputs.
module gpio_sync2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_pattern_sequencer.sv
// Drives GPIO test patterns at a prescaled step rate and runs a one-shot
// pin-pair loopback check (pin 2k drives, pin 2k+1 reads back).
module gpio_pattern_sequencer
  import gpiotest_pkg::*;
#(
  parameter int NUM_PINS      = NUM_PINS_DEFAULT,
  parameter int CLK_HZ        = CLK_HZ_DEFAULT,
  parameter int STEP_HZ       = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic [1:0]                  mode,
  input  logic [NUM_PINS-1:0]         gpio_i,
  output logic [NUM_PINS-1:0]         gpio_o,
  output logic [NUM_PINS-1:0]         gpio_oe,
  output logic [$clog2(NUM_PINS)-1:0] seq_o,
  output logic                        busy,
  output logic                        done,
  output logic [NUM_PINS/2-1:0]       fail_mask
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int SW  = $clog2(NUM_PINS);
  localparam int NP  = NUM_PINS / 2;
  localparam int CW  = $clog2(SETTLE_CYCLES);

  localparam logic [PW-1:0] PRE_MAX   = PW'(DIV - 1);
  localparam logic [CW-1:0] SET_MAX   = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] LAST_PIN  = SW'(NUM_PINS - 1);
  localparam logic [SW-1:0] LAST_PAIR = SW'(NP - 1);
  localparam logic [NUM_PINS-1:0] ONE = {{(NUM_PINS-1){1'b0}}, 1'b1};

  state_t              state;
  mode_t               mode_q;
  logic [PW-1:0]       presc;
  logic [CW-1:0]       settle;
  logic [NUM_PINS-1:0] count;
  logic                phase;
  logic [NUM_PINS-1:0] gpio_s;

  logic                tick;
  logic [NUM_PINS-1:0] count_nxt;
  logic [SW-1:0]       walk_nxt;
  logic [SW-1:0]       odd_pin;
  logic [SW-1:0]       next_even;
  logic                mism;

  gpio_sync2 #(.W(NUM_PINS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gpio_i),
    .q     (gpio_s)
  );

  function automatic logic [NUM_PINS-1:0] run_pat(mode_t m, logic [SW-1:0] s,
                                                   logic [NUM_PINS-1:0] c);
    logic [NUM_PINS-1:0] oh;
    oh = ONE << s;
    case (m)
      WALK0:   return ~oh;
      COUNT:   return c;
      default: return oh;
    endcase
  endfunction

  always_comb begin
    tick      = (presc == PRE_MAX);
    count_nxt = count + 1'b1;
    walk_nxt  = (seq_o == LAST_PIN) ? '0 : seq_o + 1'b1;
    odd_pin   = (seq_o << 1) | SW'(1);
    next_even = (seq_o + 1'b1) << 1;
    mism      = gpio_s[odd_pin] ^ phase;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= WALK1;
      presc     <= '0;
      settle    <= '0;
      count     <= '0;
      phase     <= 1'b0;
      gpio_o    <= '0;
      gpio_oe   <= '0;
      seq_o     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail_mask <= '0;
    end else if (stop) begin
      // stop releases the pins but keeps the last loopback verdict visible
      state   <= IDLE;
      gpio_oe <= '0;
      gpio_o  <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          mode_q <= mode_t'(mode);
          presc  <= '0;
          settle <= '0;
          seq_o  <= '0;
          count  <= '0;
          done   <= 1'b0;
          busy   <= 1'b1;
          if (mode_t'(mode) == LOOPBACK) begin
            fail_mask <= '0;
            phase     <= 1'b1;
            gpio_oe   <= ONE;
            gpio_o    <= ONE;
            state     <= LB_DRIVE;
          end else begin
            gpio_oe <= '1;
            gpio_o  <= run_pat(mode_t'(mode), '0, '0);
            state   <= RUN;
          end
        end
        RUN: begin
          presc <= tick ? '0 : presc + 1'b1;
          if (tick) begin
            if (mode_q == COUNT) begin
              count  <= count_nxt;
              seq_o  <= count_nxt[SW-1:0];
              gpio_o <= count_nxt;
            end else begin
              seq_o  <= walk_nxt;
              gpio_o <= run_pat(mode_q, walk_nxt, count);
            end
          end
        end
        LB_DRIVE: begin
          if (settle == SET_MAX) begin
            settle <= '0;
            state  <= LB_SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        LB_SAMPLE: begin
          fail_mask <= fail_mask | (NP'(mism) << seq_o);
          if (phase) begin
            phase  <= 1'b0;
            gpio_o <= '0;
            state  <= LB_DRIVE;
          end else if (seq_o == LAST_PAIR) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            gpio_oe <= '0;
            gpio_o  <= '0;
            state   <= DONE;
          end else begin
            seq_o   <= seq_o + 1'b1;
            phase   <= 1'b1;
            gpio_oe <= ONE << next_even;
            gpio_o  <= ONE << next_even;
            state   <= LB_DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_pattern_sequencer.sv
// Directed bench: pattern modes, stop/start edge cases, loopback pass/fault, async reset.
module tb_gpio_pattern_sequencer;
  import gpiotest_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] gpio_i, gpio_o, gpio_oe;
  logic [4:0]  seq_o;
  logic        busy, done;
  logic [15:0] fail_mask;
  logic        fault_en = 1'b0;

  logic        start4 = 1'b0, stop4 = 1'b0;
  logic [1:0]  mode4 = 2'd0;
  logic [3:0]  gpio_i4, gpio_o4, gpio_oe4;
  logic [1:0]  seq4, fail4;
  logic        busy4, done4;

  int tests = 0;
  int fails = 0;
  int n;
  logic [31:0] sbq[$];

  always #5 clk = ~clk;

  gpio_pattern_sequencer #(.NUM_PINS(32), .CLK_HZ(12), .STEP_HZ(4), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .seq_o(seq_o),
    .busy(busy), .done(done), .fail_mask(fail_mask)
  );

  // small instance so the COUNT all-ones wrap is reachable in a few ticks
  gpio_pattern_sequencer #(.NUM_PINS(4), .CLK_HZ(12), .STEP_HZ(4), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4), .mode(mode4),
    .gpio_i(gpio_i4), .gpio_o(gpio_o4), .gpio_oe(gpio_oe4), .seq_o(seq4),
    .busy(busy4), .done(done4), .fail_mask(fail4)
  );

  assign gpio_i4 = '0;

  // board loopback: odd pin sees its even partner when driven; two stuck pins on demand
  always_comb begin
    gpio_i = '0;
    for (int k = 0; k < 16; k++)
      if (gpio_oe[2*k]) gpio_i[2*k+1] = gpio_o[2*k];
    if (fault_en) begin
      gpio_i[7]  = 1'b0;
      gpio_i[31] = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    sbq.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: got %h with no expected value queued", tag, obs);
    end else begin
      chk(tag, obs, sbq.pop_front());
    end
  endtask

  task automatic go(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 400) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_oe", gpio_oe, 32'h0);
    chk("rst_o", gpio_o, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_mask", {16'b0, fail_mask}, 32'h0);
    chk("rst_seq", {27'b0, seq_o}, 32'h0);
    #4 rst_n = 1'b1;
    step();

    // WALK1, with an ignored start mid-run
    go(2'd0);
    chk("w1_oe", gpio_oe, 32'hFFFF_FFFF);
    chk("w1_busy", {31'b0, busy}, 32'h1);
    push(32'h1);
    pop_chk("w1_o0", gpio_o);
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) begin mode = 2'd3; start = 1'b1; end
      step();
      start = 1'b0;
      step();
      step();
      push(32'h1 << (i % 32));
      pop_chk("w1_o", gpio_o);
      if (i == 5) chk("w1_ign_oe", gpio_oe, 32'hFFFF_FFFF);
    end
    chk("w1_wrap_seq", {27'b0, seq_o}, 32'h0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("w1_stop_busy", {31'b0, busy}, 32'h0);
    chk("w1_stop_oe", gpio_oe, 32'h0);

    // WALK0 and stop
    go(2'd1);
    push(32'hFFFF_FFFE);
    pop_chk("w0_o0", gpio_o);
    repeat (3) step();
    push(32'hFFFF_FFFD);
    pop_chk("w0_o1", gpio_o);
    chk("w0_seq", {27'b0, seq_o}, 32'h1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("w0_stop_busy", {31'b0, busy}, 32'h0);
    chk("w0_stop_oe", gpio_oe, 32'h0);

    // COUNT on the 32-pin instance
    go(2'd2);
    push(32'h0);
    pop_chk("cnt_o0", gpio_o);
    repeat (3) step();
    push(32'h1);
    pop_chk("cnt_o1", gpio_o);
    repeat (3) step();
    push(32'h2);
    pop_chk("cnt_o2", gpio_o);
    chk("cnt_seq", {27'b0, seq_o}, 32'h2);
    stop = 1'b1; step(); stop = 1'b0;

    // start and stop together in IDLE: stop wins
    mode = 2'd0; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", {31'b0, busy}, 32'h0);
    chk("ss_oe", gpio_oe, 32'h0);
    repeat (3) step();
    chk("ss_oe_later", gpio_oe, 32'h0);

    // COUNT wrap on the 4-pin instance
    mode4 = 2'd2; start4 = 1'b1; step(); start4 = 1'b0;
    push(32'h0);
    pop_chk("cnt4_o0", {28'b0, gpio_o4});
    for (int i = 1; i <= 16; i++) begin
      repeat (3) step();
      push(32'(i % 16));
      pop_chk("cnt4_o", {28'b0, gpio_o4});
      if (i == 15) chk("cnt4_seq", {30'b0, seq4}, 32'h3);
    end
    chk("cnt4_oe", {28'b0, gpio_oe4}, 32'hF);

    // LOOPBACK, clean wiring
    go(2'd3);
    chk("lb_oe0", gpio_oe, 32'h1);
    chk("lb_o0", gpio_o, 32'h1);
    chk("lb_busy", {31'b0, busy}, 32'h1);
    wait_done(n);
    chk("lb_cycles", 32'(n), 32'd160);
    chk("lb_mask", {16'b0, fail_mask}, 32'h0);
    chk("lb_done_busy", {31'b0, busy}, 32'h0);
    chk("lb_done_oe", gpio_oe, 32'h0);
    chk("lb_done_o", gpio_o, 32'h0);
    stop = 1'b1; step(); stop = 1'b0;
    chk("lb_stop_done", {31'b0, done}, 32'h1);

    // LOOPBACK with pair 3 stuck-at-0 and pair 15 stuck-at-1
    fault_en = 1'b1;
    go(2'd3);
    chk("lbf_done_clr", {31'b0, done}, 32'h0);
    wait_done(n);
    chk("lbf_cycles", 32'(n), 32'd160);
    chk("lbf_mask", {16'b0, fail_mask}, 32'h8008);

    // restart from DONE with clean wiring clears the mask
    fault_en = 1'b0;
    go(2'd3);
    chk("lbr_mask_clr", {16'b0, fail_mask}, 32'h0);
    wait_done(n);
    chk("lbr_mask", {16'b0, fail_mask}, 32'h0);

    // faults again, then async reset while pair 4 is driving phase 0
    fault_en = 1'b1;
    go(2'd3);
    repeat (45) step();
    chk("lbx_oe", gpio_oe, 32'h100);
    chk("lbx_seq", {27'b0, seq_o}, 32'h4);
    chk("lbx_mask", {16'b0, fail_mask}, 32'h0008);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_oe", gpio_oe, 32'h0);
    chk("arst_o", gpio_o, 32'h0);
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_seq", {27'b0, seq_o}, 32'h0);
    chk("arst_mask", {16'b0, fail_mask}, 32'h0);
    #3 rst_n = 1'b1;
    fault_en = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_sequencer.md
Name: gpio_pattern_sequencer

Overview:
Pattern controller for the 32-pin GPIO test design on the UP5K board. It drives all GPIO pins with selectable test patterns, stepped by an internal prescaler off the 12 MHz `clk`. It also runs a one-shot pin-pair loopback check and reports a per-pair fail mask. It sits between the top-level pin wiring and the status/LED logic, and replaces free-running `seq` counting with a sequenced, restartable test.

Parameters:
NUM_PINS, 32, GPIO pins driven; must be even.
CLK_HZ, 12_000_000, input clock frequency.
STEP_HZ, 4, pattern step rate; DIV = CLK_HZ/STEP_HZ cycles per step; DIV >= 2.
SETTLE_CYCLES, 8, loopback wait after a drive change before sampling; >= 3.

Ports:
clk  in  1  system clock (12 MHz)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run with `mode`
stop  in  1  level; returns to IDLE next cycle
mode  in  2  0=WALK1, 1=WALK0, 2=COUNT, 3=LOOPBACK; sampled on start
gpio_i  in  NUM_PINS  pad input values
gpio_o  out  NUM_PINS  pad output values
gpio_oe  out  NUM_PINS  pad output enables (1=drive)
seq_o  out  $clog2(NUM_PINS)  current pin/pair index
busy  out  1  run in progress
done  out  1  loopback finished; held until next start
fail_mask  out  NUM_PINS/2  bit k=1: pair k failed loopback

Behaviour:
- Clock is `clk`. Reset is `rst_n`: one clock, asynchronous, active-low.
- Reset values: gpio_o=0, gpio_oe=0, seq_o=0, busy=0, done=0, fail_mask=0, state IDLE, prescaler=0, count=0.
- States: IDLE, RUN, LB_DRIVE, LB_SAMPLE, DONE.
- IDLE / DONE + start:
  - Latch mode; clear prescaler, seq, count and done.
  - LOOPBACK clears fail_mask and goes to LB_DRIVE. Other modes go to RUN.
  - busy=1 from the cycle after start.
- start while busy is ignored.
- stop has priority over start and tick in every state:
  - Next state IDLE; gpio_oe=0, busy=0.
  - fail_mask and done are held.
- Prescaler (RUN only):
  - Counts 0..DIV-1 and wraps.
  - tick is asserted in the cycle the count equals DIV-1, so the first tick comes DIV cycles after entering RUN.
  - Width is $clog2(DIV).
- RUN output rules (gpio_oe all ones; outputs registered, updating the cycle after tick):
  - WALK1: gpio_o = 1 << seq_o.
  - WALK0: gpio_o = ~(1 << seq_o).
  - seq_o increments per tick and wraps NUM_PINS-1 -> 0.
  - COUNT: gpio_o = count (NUM_PINS-bit), increments per tick, wraps all-ones -> 0. seq_o = count[low bits].
  - RUN continues until stop.
- LOOPBACK (prescaler unused; seq_o = pair index k, 0..NUM_PINS/2-1):
  - Only pin 2k is enabled: gpio_oe = 1 << 2k.
  - Pin 2k+1 is read through a 2-flop synchronizer.
  - Phase p=1 then p=0:
    - LB_DRIVE drives gpio_o[2k]=p for SETTLE_CYCLES cycles, then enters LB_SAMPLE.
    - LB_SAMPLE (1 cycle) compares synced gpio_i[2k+1] against p. A mismatch sets fail_mask[k]; the bit stays sticky until the next LOOPBACK start.
  - After p=0 of pair k, advance k.
  - After the last pair: DONE with done=1, busy=0, gpio_oe=0, gpio_o=0.
- One pair takes 2*(SETTLE_CYCLES+1) cycles. A full check takes NUM_PINS*(SETTLE_CYCLES+1) cycles.
- Asynchronous reset mid-run forces all reset values immediately, including gpio_oe=0 (pins released).
- stop and start in the same cycle: stop wins.

Decomposition:
- gpiotest_pkg:
  - mode_t enum (WALK1, WALK0, COUNT, LOOPBACK).
  - state_t enum (IDLE, RUN, LB_DRIVE, LB_SAMPLE, DONE).
  - NUM_PINS_DEFAULT = 32.
  - CLK_HZ_DEFAULT = 12_000_000.
- Sub-module gpio_sync2: parameterised-width 2-flop synchronizer for gpio_i, reset to 0 by rst_n.
- Prescaler and FSM stay in gpio_pattern_sequencer.

Test Plan:
- Benches use CLK_HZ=12, STEP_HZ=4 (DIV=3), SETTLE_CYCLES=4 to keep runs short.
- WALK1: start, mode=0 -> gpio_oe=32'hFFFFFFFF; gpio_o=32'h00000001, then 32'h00000002 3 cycles later. After 32 ticks, seq_o wraps to 0 and gpio_o=32'h00000001.
- WALK0 + stop: start, mode=1 -> gpio_o=32'hFFFFFFFE, then 32'hFFFFFFFD. stop asserted -> next cycle busy=0, gpio_oe=0.
- COUNT wrap: preload by running 2^NUM_PINS ticks, or force count=32'hFFFFFFFF -> next tick gpio_o=32'h00000000.
- LOOPBACK pass: bench ties gpio_i[2k+1]=gpio_o[2k] when gpio_oe[2k]=1 -> done=1 after 32*5=160 cycles; fail_mask=16'h0000; busy=0; gpio_oe=0.
- LOOPBACK faults: pair 3 stuck-at-0 and pair 15 stuck-at-1 -> fail_mask=16'h8008. A restart in LOOPBACK clears fail_mask to 0 at start.
- Reset/start edge cases:
  - Assert rst_n=0 mid-LB_DRIVE -> all outputs reset in the same timestep (asynchronous).
  - start while busy is ignored.
  - Simultaneous start+stop in IDLE -> remains IDLE.
